// File: rtl/round_judge_pkg.sv
// Shared scoring definitions: move and result encodings, and the round FSM states.
// Result encodings are also consumed by scoreupdate.
package round_judge_pkg;

  localparam logic [1:0] MOVE_NONE     = 2'b00;
  localparam logic [1:0] MOVE_ROCK     = 2'b01;
  localparam logic [1:0] MOVE_PAPER    = 2'b10;
  localparam logic [1:0] MOVE_SCISSORS = 2'b11;

  // bit0 marks a decisive result
  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_P1WIN = 2'b01;
  localparam logic [1:0] RES_DRAW  = 2'b10;
  localparam logic [1:0] RES_P2WIN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_JUDGE   = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/round_judge_timer.sv
// Loadable down-counter that saturates at zero; reused for the collect timeout and the hold time.
module round_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // load wins over decrement; the count parks at zero instead of wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/round_judge.sv
// One rock-paper-scissors round: arm on start, lock both moves under a timeout,
// judge, then hold the result for a fixed time before accepting another start.
module round_judge
  import round_judge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] p1_move,
  input  logic       p1_lock,
  input  logic [1:0] p2_move,
  input  logic       p2_lock,
  output logic [1:0] matchresult,
  output logic       result_valid,
  output logic       busy,
  output logic       p1_locked,
  output logic       p2_locked,
  output logic       timed_out
);

  localparam int TMR_W = $clog2(max_int(TIMEOUT_CYCLES, HOLD_CYCLES));
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  state_e           r_state;
  state_e           w_next;
  logic [1:0]       r_p1_mv;
  logic [1:0]       r_p2_mv;
  logic             r_p1_locked;
  logic             r_p2_locked;
  logic [1:0]       r_matchresult;
  logic             r_result_valid;
  logic             r_busy;
  logic             r_timed_out;
  logic             w_p1_acc;
  logic             w_p2_acc;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_zero;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == MOVE_ROCK)     && (b == MOVE_SCISSORS)) ||
           ((a == MOVE_SCISSORS) && (b == MOVE_PAPER))    ||
           ((a == MOVE_PAPER)    && (b == MOVE_ROCK));
  endfunction

  // An absent player forfeits to the one who locked; nobody locking is a draw.
  function automatic logic [1:0] judge_round(input logic [1:0] m1, input logic [1:0] m2,
                                             input logic l1, input logic l2);
    logic [1:0] res;
    if (l1 && l2) begin
      if (m1 == m2)          res = RES_DRAW;
      else if (beats(m1, m2)) res = RES_P1WIN;
      else                    res = RES_P2WIN;
    end else if (l1) begin
      res = RES_P1WIN;
    end else if (l2) begin
      res = RES_P2WIN;
    end else begin
      res = RES_DRAW;
    end
    return res;
  endfunction

  assign w_p1_acc = (r_state == ST_COLLECT) && p1_lock && (p1_move != MOVE_NONE) && !r_p1_locked;
  assign w_p2_acc = (r_state == ST_COLLECT) && p2_lock && (p2_move != MOVE_NONE) && !r_p2_locked;

  round_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = TO_LOAD;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next     = ST_COLLECT;
          w_tmr_load = 1'b1;
        end
      end
      ST_COLLECT: begin
        w_tmr_en = 1'b1;
        // locks sampled on this edge count, even on the expiry edge
        if ((r_p1_locked || w_p1_acc) && (r_p2_locked || w_p2_acc)) w_next = ST_JUDGE;
        else if (w_tmr_zero)                                        w_next = ST_JUDGE;
      end
      ST_JUDGE: begin
        w_next     = ST_HOLD;
        w_tmr_load = 1'b1;
        w_tmr_val  = HOLD_LOAD;
      end
      ST_HOLD: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p1_mv        <= MOVE_NONE;
      r_p2_mv        <= MOVE_NONE;
      r_p1_locked    <= 1'b0;
      r_p2_locked    <= 1'b0;
      r_matchresult  <= RES_NONE;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_timed_out    <= 1'b0;
    end else begin
      r_result_valid <= (r_state == ST_JUDGE);
      r_busy         <= (w_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_p1_mv       <= MOVE_NONE;
            r_p2_mv       <= MOVE_NONE;
            r_p1_locked   <= 1'b0;
            r_p2_locked   <= 1'b0;
            r_matchresult <= RES_NONE;
            r_timed_out   <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (w_p1_acc) begin
            r_p1_mv     <= p1_move;
            r_p1_locked <= 1'b1;
          end
          if (w_p2_acc) begin
            r_p2_mv     <= p2_move;
            r_p2_locked <= 1'b1;
          end
        end
        ST_JUDGE: begin
          r_matchresult <= judge_round(r_p1_mv, r_p2_mv, r_p1_locked, r_p2_locked);
          // JUDGE is only reached without both locks when the timer expired
          r_timed_out   <= !(r_p1_locked && r_p2_locked);
        end
        default: ;
      endcase
    end
  end

  assign matchresult  = r_matchresult;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign p1_locked    = r_p1_locked;
  assign p2_locked    = r_p2_locked;
  assign timed_out    = r_timed_out;

endmodule
